// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode constants, the accumulator-ALU FSM state
// encoding and the default datapath width. Used by the ALU, register file and
// decoder so that all of them agree on the encodings.
package cpu_defs;

  localparam int unsigned DataWidthDef = 8;

  // Opcode values; 10..15 are reserved.
  localparam int unsigned OpNop  = 0;
  localparam int unsigned OpLoad = 1;
  localparam int unsigned OpAdd  = 2;
  localparam int unsigned OpSub  = 3;
  localparam int unsigned OpAnd  = 4;
  localparam int unsigned OpOr   = 5;
  localparam int unsigned OpXor  = 6;
  localparam int unsigned OpShl  = 7;
  localparam int unsigned OpShr  = 8;
  localparam int unsigned OpMul  = 9;

  typedef enum logic {
    StIdle,
    StMul
  } alu_state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one partial-product step per clock.
// Ports:
//   clk, rst_n   clock, async active-low reset (aborts a multiply in flight)
//   start_i      load operands and begin; ignored while busy_o
//   mcand_i      multiplicand
//   mplier_i     multiplier
//   busy_o       a multiply is in progress
//   last_o       the coming edge performs the final step
//   product_o    low Width bits of the product, valid while last_o
//   overflow_o   any product bit above Width-1 set, valid while last_o
module mul_seq #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [Width-1:0] mcand_i,
  input  logic [Width-1:0] mplier_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [Width-1:0] product_o,
  output logic             overflow_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [2*Width-1:0] mcand_q, mcand_d;
  logic [2*Width-1:0] prod_q, prod_d;
  logic [2*Width-1:0] step_sum;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;

  assign step_sum   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign last_o     = busy_q && (cnt_q == CntW'(Width - 1));
  assign busy_o     = busy_q;
  // Exposed from the step adder so the owner can write the result on the final edge.
  assign product_o  = step_sum[Width-1:0];
  assign overflow_o = |step_sum[2*Width-1:Width];

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (busy_q) begin
      prod_d   = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_o) begin
        busy_d = 1'b0;
      end
    end else if (start_i) begin
      mcand_d  = {{Width{1'b0}}, mcand_i};
      mplier_d = mplier_i;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU with single-cycle ops and a multi-cycle shift-add multiply.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   op_valid/op_ready   operation handshake; ready is low only during a multiply
//   op_code             operation select (cpu_defs opcodes)
//   reg_data, imm       operand sources, chosen by use_imm
//   acc                 accumulator (also register file write data)
//   zero, carry         result flags
//   illegal             last accepted opcode was reserved
//   done                one-cycle completion pulse
module acc_alu
  import cpu_defs::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [OP_WIDTH-1:0]   op_code,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  use_imm,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  zero,
  output logic                  carry,
  output logic                  illegal,
  output logic                  done
);

  alu_state_e            state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  zero_q, carry_q, illegal_q, done_q;

  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH:0]   sum_w, diff_w;
  logic [DATA_WIDTH-1:0] res_acc;
  logic                  res_c, wr_acc, is_mul, is_rsv;
  int unsigned           op_int;

  logic                  mul_start, mul_busy, mul_last, mul_ovf;
  logic [DATA_WIDTH-1:0] mul_prod;

  assign operand = use_imm ? imm : reg_data;
  assign sum_w   = {1'b0, acc_q} + {1'b0, operand};
  assign diff_w  = {1'b0, acc_q} - {1'b0, operand};

  always_comb begin
    op_int  = int'(op_code);
    res_acc = acc_q;
    res_c   = 1'b0;
    wr_acc  = 1'b1;
    is_mul  = 1'b0;
    is_rsv  = 1'b0;
    case (op_int)
      OpNop:  wr_acc = 1'b0;
      OpLoad: res_acc = operand;
      OpAdd:  {res_c, res_acc} = sum_w;
      OpSub:  {res_c, res_acc} = diff_w;  // top bit of the wrapped difference is the borrow
      OpAnd:  res_acc = acc_q & operand;
      OpOr:   res_acc = acc_q | operand;
      OpXor:  res_acc = acc_q ^ operand;
      OpShl: begin
        res_acc = acc_q << 1;
        res_c   = acc_q[DATA_WIDTH-1];
      end
      OpShr: begin
        res_acc = acc_q >> 1;
        res_c   = acc_q[0];
      end
      OpMul: begin
        wr_acc = 1'b0;
        is_mul = 1'b1;
      end
      default: begin
        wr_acc = 1'b0;
        is_rsv = 1'b1;
      end
    endcase
  end

  assign mul_start = (state_q == StIdle) && op_valid && is_mul;

  mul_seq #(
    .Width (DATA_WIDTH)
  ) u_mul_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (mul_start),
    .mcand_i    (operand),
    .mplier_i   (acc_q),
    .busy_o     (mul_busy),
    .last_o     (mul_last),
    .product_o  (mul_prod),
    .overflow_o (mul_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      zero_q    <= 1'b1;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (op_valid) begin
            if (is_rsv) begin
              illegal_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              illegal_q <= 1'b0;
              if (is_mul) begin
                state_q <= StMul;
              end else begin
                done_q <= 1'b1;
                if (wr_acc) begin
                  acc_q   <= res_acc;
                  zero_q  <= (res_acc == '0);
                  carry_q <= res_c;
                end
              end
            end
          end
        end
        StMul: begin
          // Requests arriving here are ignored; op_ready is low so upstream holds them.
          if (mul_last) begin
            acc_q   <= mul_prod;
            zero_q  <= (mul_prod == '0);
            carry_q <= mul_ovf;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready depends on registered state only, never on op_valid.
  assign op_ready = (state_q == StIdle);
  assign acc      = acc_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign illegal  = illegal_q;
  assign done     = done_q;

  logic unused_busy;
  assign unused_busy = mul_busy;

endmodule

// File: tb/tb_acc_alu.sv
module tb_acc_alu;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op_code;
  logic [DW-1:0] reg_data;
  logic [DW-1:0] imm;
  logic          use_imm;
  logic [DW-1:0] acc;
  logic          zero, carry, illegal, done;

  acc_alu #(
    .DATA_WIDTH (DW),
    .OP_WIDTH   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .reg_data (reg_data),
    .imm      (imm),
    .use_imm  (use_imm),
    .acc      (acc),
    .zero     (zero),
    .carry    (carry),
    .illegal  (illegal),
    .done     (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_acc, m_zero, m_carry, m_ill;

  typedef struct {
    int op; bit ui; int im; int rd;
    int e_acc; int e_zero; int e_carry; int e_ill; int e_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_zero = 1; m_carry = 0; m_ill = 0;
  endtask

  // Behavioural model from the opcode rules, plain integer arithmetic.
  task automatic model_op(input int op, input int b, output int lat);
    int a, r, c;
    bit wr;
    a = m_acc; r = a; c = 0; wr = 1; lat = 1;
    case (op)
      0: begin wr = 0; m_ill = 0; end
      1: r = b;
      2: begin r = (a + b) % 256; c = (a + b) > 255; end
      3: begin r = (a - b + 256) % 256; c = b > a; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: begin r = (a * 2) % 256; c = a / 128; end
      8: begin r = a / 2; c = a % 2; end
      9: begin r = (a * b) % 256; c = (a * b) > 255; lat = 9; end
      default: begin wr = 0; m_ill = 1; end
    endcase
    if (op >= 1 && op <= 9) m_ill = 0;
    if (wr) begin
      m_acc = r; m_zero = (r == 0); m_carry = c;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic do_op(input int op, input bit ui, input int im, input int rd,
                       output int lat, output int low);
    op_valid = 1'b1;
    op_code  = 4'(op);
    imm      = DW'(im);
    reg_data = DW'(rd);
    use_imm  = ui;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    // Operands must only matter at the accepting edge.
    op_code  = 4'($urandom);
    imm      = DW'($urandom);
    reg_data = DW'($urandom);
    use_imm  = 1'($urandom);
    lat = 0;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (!op_ready) low++;
      if (done) break;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".acc"}, int'(acc), m_acc);
    check({tag, ".zero"}, int'(zero), m_zero);
    check({tag, ".carry"}, int'(carry), m_carry);
    check({tag, ".illegal"}, int'(illegal), m_ill);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, low, elat, b, cyc;
    bit ui;
    int op, im, rd;

    op_valid = 1'b0; op_code = '0; reg_data = '0; imm = '0; use_imm = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("reset.ready", int'(op_ready), 1);
    check("reset.done", int'(done), 0);
    check_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed table ----
    vecs.push_back('{1, 1, 'hF0, 'h00, 'hF0, 0, 0, 0, 1});
    vecs.push_back('{2, 1, 'h20, 'h00, 'h10, 0, 1, 0, 1});
    vecs.push_back('{1, 1, 'h55, 'h00, 'h55, 0, 0, 0, 1});
    vecs.push_back('{3, 0, 'hAA, 'h55, 'h00, 1, 0, 0, 1});
    vecs.push_back('{3, 1, 'h01, 'h00, 'hFF, 0, 1, 0, 1});
    vecs.push_back('{1, 1, 'h0D, 'h00, 'h0D, 0, 0, 0, 1});
    vecs.push_back('{9, 1, 'h0B, 'h00, 'h8F, 0, 0, 0, 9});
    vecs.push_back('{1, 1, 'h20, 'h00, 'h20, 0, 0, 0, 1});
    vecs.push_back('{9, 0, 'h00, 'h10, 'h00, 1, 1, 0, 9});
    vecs.push_back('{12, 1, 'h77, 'h00, 'h00, 1, 1, 1, 1});
    vecs.push_back('{0, 1, 'h33, 'h00, 'h00, 1, 1, 0, 1});
    vecs.push_back('{1, 0, 'h00, 'h81, 'h81, 0, 0, 0, 1});
    vecs.push_back('{7, 1, 'h00, 'h00, 'h02, 0, 1, 0, 1});
    vecs.push_back('{8, 1, 'h00, 'h00, 'h01, 0, 0, 0, 1});
    vecs.push_back('{8, 1, 'h00, 'h00, 'h00, 1, 1, 0, 1});
    vecs.push_back('{1, 1, 'hCC, 'h00, 'hCC, 0, 0, 0, 1});
    vecs.push_back('{4, 1, 'hF0, 'h00, 'hC0, 0, 0, 0, 1});
    vecs.push_back('{5, 0, 'h00, 'h03, 'hC3, 0, 0, 0, 1});
    vecs.push_back('{6, 1, 'hFF, 'h00, 'h3C, 0, 0, 0, 1});
    vecs.push_back('{15, 1, 'h00, 'h00, 'h3C, 0, 0, 1, 1});
    vecs.push_back('{2, 1, 'hC4, 'h00, 'h00, 1, 1, 0, 1});

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].ui, vecs[i].im, vecs[i].rd, lat, low);
      model_op(vecs[i].op, vecs[i].ui ? vecs[i].im : vecs[i].rd, elat);
      check($sformatf("vec%0d.acc", i), int'(acc), vecs[i].e_acc);
      check($sformatf("vec%0d.zero", i), int'(zero), vecs[i].e_zero);
      check($sformatf("vec%0d.carry", i), int'(carry), vecs[i].e_carry);
      check($sformatf("vec%0d.illegal", i), int'(illegal), vecs[i].e_ill);
      check($sformatf("vec%0d.latency", i), lat, vecs[i].e_lat);
      if (vecs[i].op == 9) check($sformatf("vec%0d.ready_low", i), low, 8);
    end
    @(negedge clk);
    check("table.done_single_pulse", int'(done), 0);

    // ---- ADD held during MUL is ignored, then accepted after ready rises ----
    do_op(1, 1, 'h20, 0, lat, low);
    model_op(1, 'h20, elat);
    op_valid = 1'b1; op_code = 4'd9; imm = 8'h10; use_imm = 1'b1;
    @(posedge clk);
    #1;
    op_code = 4'd2; imm = 8'h05; use_imm = 1'b1;  // held ADD
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      check("mulhold.acc_kept", int'(acc), 'h20);
      check("mulhold.ready_low", int'(op_ready), 0);
    end
    model_op(9, 'h10, elat);
    check("mulhold.latency", cyc, 9);
    check("mulhold.ready", int'(op_ready), 1);
    check_state("mulhold.mul");
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    model_op(2, 'h05, elat);
    @(negedge clk);
    check("mulhold.add_done", int'(done), 1);
    check_state("mulhold.add");
    @(negedge clk);
    check("mulhold.done_pulse", int'(done), 0);

    // ---- reset during MUL ----
    do_op(1, 1, 'h07, 0, lat, low);
    model_op(1, 'h07, elat);
    op_valid = 1'b1; op_code = 4'd9; imm = 8'h03; use_imm = 1'b1;
    @(posedge clk);  // E0
    #1 op_valid = 1'b0;
    @(posedge clk);  // E1
    @(posedge clk);  // E2
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mulrst.ready", int'(op_ready), 1);
    check("mulrst.done", int'(done), 0);
    check_state("mulrst");
    @(negedge clk);
    check("mulrst.done_held", int'(done), 0);
    rst_n = 1'b1;
    do_op(1, 1, 'h09, 0, lat, low);
    model_op(1, 'h09, elat);
    check("mulrst.load_latency", lat, 1);
    check_state("mulrst.load");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mulrst.no_late_done", int'(done), 0);
    end
    check("mulrst.acc_stable", int'(acc), 'h09);

    // ---- randomized against the model ----
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0) op = 9;
      ui = 1'($urandom);
      im = $urandom_range(0, 255);
      rd = $urandom_range(0, 255);
      b  = ui ? im : rd;
      do_op(op, ui, im, rd, lat, low);
      model_op(op, b, elat);
      check($sformatf("rnd%0d.op%0d.latency", n, op), lat, elat);
      check_state($sformatf("rnd%0d.op%0d", n, op));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check($sformatf("rnd%0d.idle_done", n), int'(done), 0);
        check($sformatf("rnd%0d.idle_ready", n), int'(op_ready), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
